// File: rtl/dmi_reg_frontend.sv
// Core-side DMI consumer: turns DMI requests into single-outstanding register-bus accesses,
// bounds each access with a timeout and queues the DMI responses in a small FIFO.
module dmi_reg_frontend #(
    parameter int unsigned RespDepth     = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i,
    output logic        reg_abort_o
);
    localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    localparam logic [1:0] OpNop       = 2'h0;
    localparam logic [1:0] OpRead      = 2'h1;
    localparam logic [1:0] OpWrite     = 2'h2;
    localparam logic [1:0] OpReserved  = 2'h3;
    localparam logic [1:0] RespSuccess = 2'h0;
    localparam logic [1:0] RespErr     = 2'h2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic              imm_pend_q, imm_pend_d;
    logic [1:0]        imm_resp_q;
    logic [TmoW-1:0]   tmo_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [33:0]       mem [RespDepth];

    logic [1:0]        req_op;
    logic              accept, busy, rsp_done, expire, push, pop, ready_d;
    logic [33:0]       push_data;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and request fields are held while valid waits.
    always_comb begin
        req_op   = dmi_req_i[33:32];
        accept   = dmi_req_valid_i & dmi_req_ready_o;
        busy     = (state_q != ST_IDLE);
        rsp_done = (state_q == ST_WAIT_RSP) & reg_rvalid_i;
        expire   = busy & (tmo_q == TmoLast) & ~rsp_done;
        push     = imm_pend_q | rsp_done | expire;
        pop      = dmi_resp_valid_o & dmi_resp_ready_i;

        if (imm_pend_q) begin
            push_data = {32'h0, imm_resp_q};
        end else if (rsp_done) begin
            push_data = {(op_q == OpRead) ? reg_rdata_i : 32'h0,
                         reg_err_i ? RespErr : RespSuccess};
        end else begin
            push_data = {32'h0, RespErr};
        end

        count_d = count_q + CntW'(push) - CntW'(pop);

        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept && (req_op == OpRead || req_op == OpWrite)) state_d = ST_ISSUE;
            ST_ISSUE:    if (expire) state_d = ST_IDLE;
                         else if (reg_gnt_i) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: if (rsp_done || expire) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        imm_pend_d = accept & (req_op == OpNop || req_op == OpReserved);
        // A pending immediate response already owns a FIFO slot.
        ready_d = (state_d == ST_IDLE) &&
                  (({1'b0, count_d} + (CntW + 1)'(imm_pend_d)) < (CntW + 1)'(RespDepth));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            op_q            <= 2'h0;
            imm_pend_q      <= 1'b0;
            imm_resp_q      <= 2'h0;
            tmo_q           <= '0;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            mem             <= '{default: '0};
            dmi_req_ready_o <= 1'b0;
            reg_req_o       <= 1'b0;
            reg_we_o        <= 1'b0;
            reg_addr_o      <= 7'h0;
            reg_wdata_o     <= 32'h0;
            reg_abort_o     <= 1'b0;
        end else begin
            state_q         <= state_d;
            dmi_req_ready_o <= ready_d;
            reg_req_o       <= (state_d == ST_ISSUE);
            reg_abort_o     <= expire;
            imm_pend_q      <= imm_pend_d;
            count_q         <= count_d;

            if (accept) begin
                op_q        <= req_op;
                reg_we_o    <= (req_op == OpWrite);
                reg_addr_o  <= dmi_req_i[40:34];
                reg_wdata_o <= dmi_req_i[31:0];
                imm_resp_q  <= (req_op == OpNop) ? RespSuccess : RespErr;
                tmo_q       <= '0;
            end else if (busy) begin
                tmo_q <= tmo_q + TmoW'(1);
            end

            if (push) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    assign dmi_resp_o       = mem[rd_ptr_q];
    assign dmi_resp_valid_o = (count_q != '0);

endmodule

// File: tb/tb_dmi_reg_frontend.sv
// Directed bench for dmi_reg_frontend: expected DMI responses are queued at request time and
// a negedge monitor pops and compares every response handed out by the DUT.
module tb_dmi_reg_frontend;
    logic        clk = 1'b0;
    logic        rst_i;
    logic [40:0] dmi_req_i;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    logic [33:0] dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [6:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_gnt_i;
    logic        reg_rvalid_i;
    logic [31:0] reg_rdata_i;
    logic        reg_err_i;
    logic        reg_abort_o;

    logic [33:0] exp_q[$];
    logic [33:0] mon_exp;
    int          checks = 0;
    int          errors = 0;
    logic        stable, seen;

    always #5 clk = ~clk;

    dmi_reg_frontend #(.RespDepth(2), .TimeoutCycles(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .dmi_req_i       (dmi_req_i),
        .dmi_req_valid_i (dmi_req_valid_i),
        .dmi_req_ready_o (dmi_req_ready_o),
        .dmi_resp_o      (dmi_resp_o),
        .dmi_resp_valid_o(dmi_resp_valid_o),
        .dmi_resp_ready_i(dmi_resp_ready_i),
        .reg_req_o       (reg_req_o),
        .reg_we_o        (reg_we_o),
        .reg_addr_o      (reg_addr_o),
        .reg_wdata_o     (reg_wdata_o),
        .reg_gnt_i       (reg_gnt_i),
        .reg_rvalid_i    (reg_rvalid_i),
        .reg_rdata_i     (reg_rdata_i),
        .reg_err_i       (reg_err_i),
        .reg_abort_o     (reg_abort_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data,
                        input logic [33:0] exp_rsp);
        int n;
        n = 0;
        dmi_req_i       = {addr, op, data};
        dmi_req_valid_i = 1'b1;
        while (!dmi_req_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("req_accept", dmi_req_ready_o, 1'b1);
        if (dmi_req_ready_o) exp_q.push_back(exp_rsp);
        tick();
        dmi_req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dmi_resp_valid_o) && n < 100) begin
            tick();
            n++;
        end
        check("drain", {exp_q.size() == 0, dmi_resp_valid_o}, 2'b10);
    endtask

    always @(negedge clk) begin
        if (!rst_i && dmi_resp_valid_o && dmi_resp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got %0h expected none", dmi_resp_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp", dmi_resp_o, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        dmi_req_i = '0;
        dmi_req_valid_i = 1'b0;
        dmi_resp_ready_i = 1'b1;
        reg_gnt_i = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_rdata_i = '0;
        reg_err_i = 1'b0;

        // Reset values
        #12;
        check("rst_ready", dmi_req_ready_o, 1'b0);
        check("rst_resp_valid", dmi_resp_valid_o, 1'b0);
        check("rst_reg_outs", {reg_req_o, reg_we_o, reg_abort_o, reg_addr_o, reg_wdata_o}, '0);
        check("rst_resp_data", dmi_resp_o, 34'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        tick();
        check("post_rst_ready", dmi_req_ready_o, 1'b1);

        // Read with immediate grant, minimum latency
        send(7'h11, 2'h1, 32'h0, {32'hDEADBEEF, 2'h0});
        check("rd_req", reg_req_o, 1'b1);
        check("rd_addr_we", {reg_addr_o, reg_we_o}, {7'h11, 1'b0});
        check("rd_ready_busy", dmi_req_ready_o, 1'b0);
        reg_gnt_i = 1'b1;
        tick();
        reg_gnt_i = 1'b0;
        check("rd_req_drop", reg_req_o, 1'b0);
        reg_rvalid_i = 1'b1;
        reg_rdata_i = 32'hDEADBEEF;
        tick();
        reg_rvalid_i = 1'b0;
        reg_rdata_i = '0;
        check("rd_latency", dmi_resp_valid_o, 1'b1);
        wait_drain();

        // Write, late grant, error response, read data ignored
        send(7'h10, 2'h2, 32'h1, {32'h0, 2'h2});
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stable &= (reg_req_o && reg_we_o && reg_addr_o == 7'h10 && reg_wdata_o == 32'h1);
            tick();
        end
        check("wr_stable", stable, 1'b1);
        check("wr_req_held", reg_req_o, 1'b1);
        reg_gnt_i = 1'b1;
        tick();
        reg_gnt_i = 1'b0;
        reg_rvalid_i = 1'b1;
        reg_err_i = 1'b1;
        reg_rdata_i = 32'h55AA55AA;
        tick();
        reg_rvalid_i = 1'b0;
        reg_err_i = 1'b0;
        reg_rdata_i = '0;
        wait_drain();

        // Reserved op: error response without any bus access
        send(7'h05, 2'h3, 32'hFFFFFFFF, {32'h0, 2'h2});
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= reg_req_o;
            tick();
        end
        check("rsv_no_req", seen, 1'b0);
        wait_drain();

        // Timeout: abort pulse 8 cycles after issue, late rvalid ignored
        send(7'h20, 2'h1, 32'h0, {32'h0, 2'h2});
        reg_gnt_i = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            seen |= reg_abort_o;
            tick();
            reg_gnt_i = 1'b0;
        end
        check("tmo_abort_early", seen, 1'b0);
        check("tmo_abort", reg_abort_o, 1'b1);
        check("tmo_req", reg_req_o, 1'b0);
        tick();
        check("tmo_abort_pulse", reg_abort_o, 1'b0);
        reg_rvalid_i = 1'b1;
        reg_gnt_i = 1'b1;
        reg_rdata_i = 32'h12345678;
        tick();
        reg_rvalid_i = 1'b0;
        reg_gnt_i = 1'b0;
        reg_rdata_i = '0;
        wait_drain();
        repeat (3) tick();
        check("tmo_stale_ignored", dmi_resp_valid_o, 1'b0);

        // rvalid in the expiry cycle wins
        send(7'h21, 2'h1, 32'h0, {32'hCAFEF00D, 2'h0});
        reg_gnt_i = 1'b1;
        tick();
        reg_gnt_i = 1'b0;
        repeat (6) tick();
        reg_rvalid_i = 1'b1;
        reg_rdata_i = 32'hCAFEF00D;
        tick();
        reg_rvalid_i = 1'b0;
        reg_rdata_i = '0;
        check("coin_no_abort", reg_abort_o, 1'b0);
        wait_drain();

        // FIFO full back-pressure with NOPs
        dmi_resp_ready_i = 1'b0;
        send(7'h00, 2'h0, 32'h0, 34'h0);
        send(7'h01, 2'h0, 32'h0, 34'h0);
        dmi_req_i = {7'h02, 2'h0, 32'h0};
        dmi_req_valid_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen |= dmi_req_ready_o;
            tick();
        end
        check("full_stall", seen, 1'b0);
        check("full_valid", dmi_resp_valid_o, 1'b1);
        dmi_resp_ready_i = 1'b1;
        tick();
        dmi_resp_ready_i = 1'b0;
        check("full_ready_after_pop", dmi_req_ready_o, 1'b1);
        exp_q.push_back(34'h0);
        tick();
        dmi_req_valid_i = 1'b0;
        dmi_resp_ready_i = 1'b1;
        wait_drain();

        // Reset while an access is outstanding and the FIFO is occupied
        dmi_resp_ready_i = 1'b0;
        send(7'h00, 2'h0, 32'h0, 34'h0);
        send(7'h11, 2'h1, 32'h0, {32'hDEADBEEF, 2'h0});
        reg_gnt_i = 1'b1;
        tick();
        reg_gnt_i = 1'b0;
        check("rst_pre_valid", dmi_resp_valid_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_outs", {reg_req_o, dmi_resp_valid_o, dmi_req_ready_o}, 3'b000);
        exp_q.delete();
        tick();
        rst_i = 1'b0;
        tick();
        check("rst_mid_release", {dmi_req_ready_o, dmi_resp_valid_o}, 2'b10);
        dmi_resp_ready_i = 1'b1;
        repeat (2) tick();

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
